// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 640x480@60 Hz text display path:
//   - the eight horizontal/vertical timing constants
//   - line/frame totals and the derived sync pulse start/end positions
//   - the 5x7 glyph cell size
//   - glyph_pack(): packs seven 5-bit row words into one 35-bit glyph,
//     row 0 in the top bits, bit 4 of each row word being column 0
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam logic [9:0] H_DISPLAY = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] V_DISPLAY = 10'd480;
  localparam logic [9:0] V_BOTTOM  = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_TOP     = 10'd33;

  localparam logic [9:0] H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;   // 800
  localparam logic [9:0] V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;   // 525
  localparam logic [9:0] H_SYNC_START = H_DISPLAY + H_FRONT;                     // 656
  localparam logic [9:0] H_SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 10'd1;    // 751
  localparam logic [9:0] V_SYNC_START = V_DISPLAY + V_BOTTOM;                    // 490
  localparam logic [9:0] V_SYNC_END   = V_DISPLAY + V_BOTTOM + V_SYNC - 10'd1;   // 491

  localparam logic [2:0] FONT_W = 3'd5;
  localparam logic [2:0] FONT_H = 3'd7;

  // Row 0 lands in bits 34:30, row 6 in bits 4:0.
  function automatic logic [34:0] glyph_pack(
    input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] r3, input logic [4:0] r4, input logic [4:0] r5,
    input logic [4:0] r6
  );
    return {r0, r1, r2, r3, r4, r5, r6};
  endfunction

endpackage

// File: rtl/font_rom_5x7.sv
// ---------------------------------------------------------------------------
// font_rom_5x7
// Purely combinational 5x7 glyph lookup (HD44780 A00 shapes) for space,
// '0'-'9', 'A'-'Z' and 'a'-'z'; every other code renders blank.
// Ports:
//   char_code [7:0] in  : character code
//   row       [2:0] in  : glyph row, 0 = top
//   col       [2:0] in  : glyph column, 0 = leftmost
//   pixel           out : glyph bit, forced to 0 outside the 5x7 cell
// ---------------------------------------------------------------------------
module font_rom_5x7
  import vga_pkg::*;
(
  input  logic [7:0] char_code,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       pixel
);

  logic [34:0] glyph_s;
  logic [5:0]  bit_idx_s;

  // Character code to packed 35-bit glyph.
  always_comb begin
    glyph_s = 35'd0;
    case (char_code)
      8'h20: glyph_s = 35'd0;
      8'h30: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E);
      8'h31: glyph_s = glyph_pack(5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E);
      8'h32: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F);
      8'h33: glyph_s = glyph_pack(5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E);
      8'h34: glyph_s = glyph_pack(5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02);
      8'h35: glyph_s = glyph_pack(5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E);
      8'h36: glyph_s = glyph_pack(5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E);
      8'h37: glyph_s = glyph_pack(5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08);
      8'h38: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E);
      8'h39: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C);
      8'h41: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11);
      8'h42: glyph_s = glyph_pack(5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E);
      8'h43: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E);
      8'h44: glyph_s = glyph_pack(5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C);
      8'h45: glyph_s = glyph_pack(5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F);
      8'h46: glyph_s = glyph_pack(5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10);
      8'h47: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F);
      8'h48: glyph_s = glyph_pack(5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11);
      8'h49: glyph_s = glyph_pack(5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E);
      8'h4A: glyph_s = glyph_pack(5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C);
      8'h4B: glyph_s = glyph_pack(5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11);
      8'h4C: glyph_s = glyph_pack(5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F);
      8'h4D: glyph_s = glyph_pack(5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11);
      8'h4E: glyph_s = glyph_pack(5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11);
      8'h4F: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E);
      8'h50: glyph_s = glyph_pack(5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10);
      8'h51: glyph_s = glyph_pack(5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D);
      8'h52: glyph_s = glyph_pack(5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11);
      8'h53: glyph_s = glyph_pack(5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E);
      8'h54: glyph_s = glyph_pack(5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04);
      8'h55: glyph_s = glyph_pack(5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E);
      8'h56: glyph_s = glyph_pack(5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04);
      8'h57: glyph_s = glyph_pack(5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A);
      8'h58: glyph_s = glyph_pack(5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11);
      8'h59: glyph_s = glyph_pack(5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04);
      8'h5A: glyph_s = glyph_pack(5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F);
      8'h61: glyph_s = glyph_pack(5'h00, 5'h00, 5'h0E, 5'h01, 5'h0F, 5'h11, 5'h0F);
      8'h62: glyph_s = glyph_pack(5'h10, 5'h10, 5'h16, 5'h19, 5'h11, 5'h11, 5'h1E);
      8'h63: glyph_s = glyph_pack(5'h00, 5'h00, 5'h0E, 5'h10, 5'h10, 5'h11, 5'h0E);
      8'h64: glyph_s = glyph_pack(5'h01, 5'h01, 5'h0D, 5'h13, 5'h11, 5'h11, 5'h0F);
      8'h65: glyph_s = glyph_pack(5'h00, 5'h00, 5'h0E, 5'h11, 5'h1F, 5'h10, 5'h0E);
      8'h66: glyph_s = glyph_pack(5'h06, 5'h09, 5'h08, 5'h1C, 5'h08, 5'h08, 5'h08);
      8'h67: glyph_s = glyph_pack(5'h00, 5'h0F, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h0E);
      8'h68: glyph_s = glyph_pack(5'h10, 5'h10, 5'h16, 5'h19, 5'h11, 5'h11, 5'h11);
      8'h69: glyph_s = glyph_pack(5'h04, 5'h00, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h0E);
      8'h6A: glyph_s = glyph_pack(5'h02, 5'h00, 5'h06, 5'h02, 5'h02, 5'h12, 5'h0C);
      8'h6B: glyph_s = glyph_pack(5'h10, 5'h10, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12);
      8'h6C: glyph_s = glyph_pack(5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E);
      8'h6D: glyph_s = glyph_pack(5'h00, 5'h00, 5'h1A, 5'h15, 5'h15, 5'h11, 5'h11);
      8'h6E: glyph_s = glyph_pack(5'h00, 5'h00, 5'h16, 5'h19, 5'h11, 5'h11, 5'h11);
      8'h6F: glyph_s = glyph_pack(5'h00, 5'h00, 5'h0E, 5'h11, 5'h11, 5'h11, 5'h0E);
      8'h70: glyph_s = glyph_pack(5'h00, 5'h00, 5'h1E, 5'h11, 5'h1E, 5'h10, 5'h10);
      8'h71: glyph_s = glyph_pack(5'h00, 5'h00, 5'h0D, 5'h13, 5'h0F, 5'h01, 5'h01);
      8'h72: glyph_s = glyph_pack(5'h00, 5'h00, 5'h16, 5'h19, 5'h10, 5'h10, 5'h10);
      8'h73: glyph_s = glyph_pack(5'h00, 5'h00, 5'h0E, 5'h10, 5'h0E, 5'h01, 5'h1E);
      8'h74: glyph_s = glyph_pack(5'h08, 5'h08, 5'h1C, 5'h08, 5'h08, 5'h09, 5'h06);
      8'h75: glyph_s = glyph_pack(5'h00, 5'h00, 5'h11, 5'h11, 5'h11, 5'h13, 5'h0D);
      8'h76: glyph_s = glyph_pack(5'h00, 5'h00, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04);
      8'h77: glyph_s = glyph_pack(5'h00, 5'h00, 5'h11, 5'h11, 5'h15, 5'h15, 5'h0A);
      8'h78: glyph_s = glyph_pack(5'h00, 5'h00, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11);
      8'h79: glyph_s = glyph_pack(5'h00, 5'h00, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h0E);
      8'h7A: glyph_s = glyph_pack(5'h00, 5'h00, 5'h1F, 5'h02, 5'h04, 5'h08, 5'h1F);
      default: glyph_s = 35'd0;
    endcase
  end

  // Pick the addressed bit; anything outside the 5x7 cell is spacing (0).
  always_comb begin
    bit_idx_s = 6'd0;
    pixel     = 1'b0;
    if ((row < FONT_H) && (col < FONT_W)) begin
      bit_idx_s = 6'd34 - ((6'(row) * 6'd5) + 6'(col));
      pixel     = glyph_s[bit_idx_s];
    end else begin
      pixel     = 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing_font.sv
// ---------------------------------------------------------------------------
// vga_timing_font
// 640x480@60 Hz timing generator (pixel/line counters with zero-latency
// sync and display-enable decode) plus the 5x7 glyph lookup.
// Timing parameters default to the package values; they are exposed so a
// reduced raster can be instantiated.
// Ports:
//   clk, rst_n           : pixel clock, async active-low reset
//   hsync, vsync         : active-low syncs
//   display_on           : high inside the visible area
//   hpos [9:0], vpos [9:0] : current column 0..799, line 0..524
//   char_code, font_row, font_col -> pixel : combinational glyph lookup
// ---------------------------------------------------------------------------
module vga_timing_font
#(
  parameter logic [9:0] H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter logic [9:0] H_FRONT   = vga_pkg::H_FRONT,
  parameter logic [9:0] H_SYNC    = vga_pkg::H_SYNC,
  parameter logic [9:0] H_BACK    = vga_pkg::H_BACK,
  parameter logic [9:0] V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter logic [9:0] V_BOTTOM  = vga_pkg::V_BOTTOM,
  parameter logic [9:0] V_SYNC    = vga_pkg::V_SYNC,
  parameter logic [9:0] V_TOP     = vga_pkg::V_TOP
)
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  input  logic [7:0] char_code,
  input  logic [2:0] font_row,
  input  logic [2:0] font_col,
  output logic       pixel
);

  localparam logic [9:0] H_LAST   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 10'd1;
  localparam logic [9:0] V_LAST   = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 10'd1;
  localparam logic [9:0] HS_START = H_DISPLAY + H_FRONT;
  localparam logic [9:0] HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 10'd1;
  localparam logic [9:0] VS_START = V_DISPLAY + V_BOTTOM;
  localparam logic [9:0] VS_END   = V_DISPLAY + V_BOTTOM + V_SYNC - 10'd1;

  logic [9:0] hpos_r;
  logic [9:0] vpos_r;

  // Pixel and line counters; both wrap to 0 on the same edge at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_r <= 10'd0;
      vpos_r <= 10'd0;
    end else if (hpos_r == H_LAST) begin
      hpos_r <= 10'd0;
      if (vpos_r == V_LAST) begin
        vpos_r <= 10'd0;
      end else begin
        vpos_r <= vpos_r + 10'd1;
      end
    end else begin
      hpos_r <= hpos_r + 10'd1;
    end
  end

  // Decodes are taken straight from the counters so they never skew
  // against hpos/vpos; vsync can only move when vpos does.
  assign hpos       = hpos_r;
  assign vpos       = vpos_r;
  assign hsync      = ~((hpos_r >= HS_START) && (hpos_r <= HS_END));
  assign vsync      = ~((vpos_r >= VS_START) && (vpos_r <= VS_END));
  assign display_on = (hpos_r < H_DISPLAY) && (vpos_r < V_DISPLAY);

  font_rom_5x7 u_font_rom (
    .char_code (char_code),
    .row       (font_row),
    .col       (font_col),
    .pixel     (pixel)
  );

endmodule

// File: tb/tb_vga_timing_font.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_font
// Directed bench: full 640x480 instance for reset and line timing, plus a
// reduced-raster instance (15 clocks x 13 lines) so several complete frames,
// the vsync window and the frame wrap fit in a short run. Glyph lookups are
// compared against hand-entered row words.
// ---------------------------------------------------------------------------
module tb_vga_timing_font;

  logic       clk;
  logic       rst_n;
  logic [7:0] char_code;
  logic [2:0] font_row;
  logic [2:0] font_col;

  logic       hsync, vsync, display_on, pixel;
  logic [9:0] hpos, vpos;
  logic       s_hsync, s_vsync, s_display_on, s_pixel;
  logic [9:0] s_hpos, s_vpos;

  int n_vec;
  int n_miss;

  // Reference counters: full raster (mh, mv) and reduced raster (sh, sv).
  int mh, mv, sh, sv;

  typedef struct packed {
    logic [7:0]  code;
    logic [34:0] bits;
  } glyph_t;

  glyph_t gtab [11];
  logic [7:0] blank_codes [6];

  vga_timing_font dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .char_code  (char_code),
    .font_row   (font_row),
    .font_col   (font_col),
    .pixel      (pixel)
  );

  // Reduced raster: H 8+2+3+2 = 15, V 6+2+2+3 = 13.
  vga_timing_font #(
    .H_DISPLAY (10'd8), .H_FRONT (10'd2), .H_SYNC (10'd3), .H_BACK (10'd2),
    .V_DISPLAY (10'd6), .V_BOTTOM (10'd2), .V_SYNC (10'd2), .V_TOP (10'd3)
  ) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .display_on (s_display_on),
    .hpos       (s_hpos),
    .vpos       (s_vpos),
    .char_code  (char_code),
    .font_row   (font_row),
    .font_col   (font_col),
    .pixel      (s_pixel)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare both instances against the reference counters.
  task automatic check_timing();
    check_val("hpos", 32'(hpos), 32'(mh));
    check_val("vpos", 32'(vpos), 32'(mv));
    check_val("hsync", 32'(hsync), 32'(!(mh >= 656 && mh <= 751)));
    check_val("vsync", 32'(vsync), 32'(!(mv >= 490 && mv <= 491)));
    check_val("display_on", 32'(display_on), 32'(mh < 640 && mv < 480));
    check_val("s_hpos", 32'(s_hpos), 32'(sh));
    check_val("s_vpos", 32'(s_vpos), 32'(sv));
    check_val("s_hsync", 32'(s_hsync), 32'(!(sh >= 10 && sh <= 12)));
    check_val("s_vsync", 32'(s_vsync), 32'(!(sv >= 8 && sv <= 9)));
    check_val("s_display_on", 32'(s_display_on), 32'(sh < 8 && sv < 6));
  endtask

  // One clock: advance the references, then compare on the falling edge.
  task automatic step_check();
    @(negedge clk);
    if (mh == 799) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    if (sh == 14) begin
      sh = 0;
      sv = (sv == 12) ? 0 : sv + 1;
    end else begin
      sh = sh + 1;
    end
    check_timing();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_hpos"}, 32'(hpos), 32'd0);
    check_val({tag, "_vpos"}, 32'(vpos), 32'd0);
    check_val({tag, "_hsync"}, 32'(hsync), 32'd1);
    check_val({tag, "_vsync"}, 32'(vsync), 32'd1);
    check_val({tag, "_display_on"}, 32'(display_on), 32'd1);
    check_val({tag, "_s_hpos"}, 32'(s_hpos), 32'd0);
    check_val({tag, "_s_vpos"}, 32'(s_vpos), 32'd0);
  endtask

  initial begin
    logic exp_bit;
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    char_code = 8'h00;
    font_row  = 3'd0;
    font_col  = 3'd0;
    mh = 0; mv = 0; sh = 0; sv = 0;

    gtab[0]  = {8'h44, 5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
    gtab[1]  = {8'h30, 5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
    gtab[2]  = {8'h32, 5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
    gtab[3]  = {8'h35, 5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
    gtab[4]  = {8'h49, 5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
    gtab[5]  = {8'h54, 5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
    gtab[6]  = {8'h69, 5'h04, 5'h00, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h0E};
    gtab[7]  = {8'h72, 5'h00, 5'h00, 5'h16, 5'h19, 5'h10, 5'h10, 5'h10};
    gtab[8]  = {8'h76, 5'h00, 5'h00, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
    gtab[9]  = {8'h6E, 5'h00, 5'h00, 5'h16, 5'h19, 5'h11, 5'h11, 5'h11};
    gtab[10] = {8'h67, 5'h00, 5'h0F, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h0E};

    blank_codes[0] = 8'h20;
    blank_codes[1] = 8'h7F;
    blank_codes[2] = 8'hFF;
    blank_codes[3] = 8'h00;
    blank_codes[4] = 8'h5B;
    blank_codes[5] = 8'h80;

    // Power-on reset held across several edges.
    repeat (3) @(negedge clk);
    check_reset_state("por");

    // Release on a falling edge; counting starts at the next rising edge.
    rst_n = 1'b1;
    #1;
    check_timing();

    // Two full lines on the full raster (hsync edges at 656/752, display_on
    // drop at 640, line wrap 799->0) and ~8.7 frames on the reduced raster.
    for (int i = 0; i < 1700; i++) step_check();

    // Advance to column 300, then reset mid-line without a clock edge.
    while (mh != 300) step_check();
    check_val("pre_rst_hpos", 32'(hpos), 32'd300);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midline");
    @(negedge clk);
    check_reset_state("midline_held");
    rst_n = 1'b1;
    mh = 0; mv = 0; sh = 0; sv = 0;
    #1;
    check_timing();
    for (int i = 0; i < 200; i++) step_check();

    // Required glyphs: scan all 8x8 addresses, outside the cell must be 0.
    for (int g = 0; g < 11; g++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          char_code = gtab[g].code;
          font_row  = 3'(r);
          font_col  = 3'(c);
          #1;
          if (r < 7 && c < 5) exp_bit = gtab[g].bits[34 - (r * 5 + c)];
          else                exp_bit = 1'b0;
          check_val("glyph", 32'(pixel), 32'(exp_bit));
        end
      end
    end

    // Spot checks called out individually.
    char_code = 8'h32; font_row = 3'd6;
    for (int c = 0; c < 5; c++) begin
      font_col = 3'(c);
      #1;
      check_val("two_row6", 32'(pixel), 32'd1);
    end
    char_code = 8'h54; font_row = 3'd0; font_col = 3'd4;
    #1;
    check_val("T_r0c4", 32'(pixel), 32'd1);
    font_row = 3'd1; font_col = 3'd0;
    #1;
    check_val("T_r1c0", 32'(pixel), 32'd0);

    // Blank and unsupported codes render nothing anywhere.
    for (int b = 0; b < 6; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          char_code = blank_codes[b];
          font_row  = 3'(r);
          font_col  = 3'(c);
          #1;
          check_val("blank", 32'(pixel), 32'd0);
        end
      end
    end

    // Every code: column 5..7 or row 7 is inter-character spacing.
    for (int code = 0; code < 256; code++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (r == 7 || c >= 5) begin
            char_code = 8'(code);
            font_row  = 3'(r);
            font_col  = 3'(c);
            #1;
            check_val("spacing", 32'(pixel), 32'd0);
            check_val("s_spacing", 32'(s_pixel), 32'd0);
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
